xadac_vmac: RTL and testbench

XADAC_VMAC -- requirements
Module: xadac_vmac

---
 rtl/xadac_pkg.sv | 60 ++++++
 rtl/xadac_ex_if.sv | 35 +++
 rtl/xadac_resp_fifo.sv | 66 ++++++
 rtl/xadac_vmac.sv | 142 ++++++++++++++
 tb/tb_xadac_vmac.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadac_pkg.sv
// Shared XADAC execute-channel types plus the vector MAC lane helpers.
// Lanes are signed 8-bit; products and sums are widened so overflow can be detected before narrowing.
package xadac_pkg;

    localparam int XLEN = 32;
    localparam int VLEN = 128;
    localparam int IdW  = 5;
    localparam int ImmW = 12;

    typedef logic [IdW-1:0]  IdT;
    typedef logic [XLEN-1:0] XlenT;
    typedef logic [VLEN-1:0] VectorT;
    typedef logic [ImmW-1:0] ImmT;

    localparam int LaneW  = 8;
    localparam int NLanes = VLEN / LaneW;
    localparam int ProdW  = 2 * LaneW;
    localparam int SumW   = ProdW + 2;

    typedef enum logic [1:0] {
        VMAC = 2'd0,
        VDOT = 2'd1,
        VADD = 2'd2,
        RSVD = 2'd3
    } VmacOpT;

    typedef struct packed {
        IdT     id;
        XlenT   rd;
        VectorT vd;
    } RespEntryT;

    function automatic logic [ProdW-1:0] sextLane(input logic [LaneW-1:0] v);
        return {{(ProdW - LaneW){v[LaneW-1]}}, v};
    endfunction

    function automatic logic [SumW-1:0] widenProd(input logic [ProdW-1:0] v);
        return {{(SumW - ProdW){v[ProdW-1]}}, v};
    endfunction

    function automatic logic [SumW-1:0] widenLane(input logic [LaneW-1:0] v);
        return {{(SumW - LaneW){v[LaneW-1]}}, v};
    endfunction

    // Clamp a widened signed lane value into the signed 8-bit range.
    function automatic logic [LaneW-1:0] satLane(input logic [SumW-1:0] v);
        logic signed [SumW-1:0] laneMax;
        logic signed [SumW-1:0] laneMin;
        laneMax = SumW'(127);
        laneMin = -SumW'(128);
        if ($signed(v) > laneMax) begin
            return 8'h7F;
        end
        if ($signed(v) < laneMin) begin
            return 8'h80;
        end
        return v[LaneW-1:0];
    endfunction

endpackage

// File: rtl/xadac_ex_if.sv
// XADAC execute channel: request carries operands and an immediate, response returns rd/vd tagged by id.
interface xadac_ex_if;
    import xadac_pkg::*;

    IdT     req_id;
    XlenT   req_rs1;
    XlenT   req_rs2;
    VectorT req_vs1;
    VectorT req_vs2;
    VectorT req_vs3;
    ImmT    req_imm;
    logic   req_valid;
    logic   req_ready;

    IdT     resp_id;
    XlenT   resp_rd;
    VectorT resp_vd;
    logic   resp_valid;
    logic   resp_ready;

    modport Slave (
        input  req_id, req_rs1, req_rs2, req_vs1, req_vs2, req_vs3, req_imm, req_valid,
        output req_ready,
        output resp_id, resp_rd, resp_vd, resp_valid,
        input  resp_ready
    );

    modport Master (
        output req_id, req_rs1, req_rs2, req_vs1, req_vs2, req_vs3, req_imm, req_valid,
        input  req_ready,
        input  resp_id, resp_rd, resp_vd, resp_valid,
        output resp_ready
    );

endinterface

// File: rtl/xadac_resp_fifo.sv
// In-order response buffer for xadac_vmac: DEPTH entries with wrap-around pointers.
// Pushes while full are ignored; the parent's credit counter keeps that from happening.
module xadac_resp_fifo
    import xadac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  RespEntryT wrEntry_i,
    input  logic      pop_i,
    output RespEntryT rdEntry_o,
    output logic      empty_o,
    output logic      full_o
);
    localparam int PtrW  = $clog2(DEPTH);
    localparam int FillW = $clog2(DEPTH + 1);

    RespEntryT         mem_q [DEPTH];
    logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
    logic [FillW-1:0]  fill_q, fill_d;
    logic              doPush;
    logic              doPop;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o   = (fill_q == '0);
    assign full_o    = (fill_q == FillW'(DEPTH));
    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;
    assign rdEntry_o = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop  ? nextPtr(rdPtr_q) : rdPtr_q;
        fill_d  = fill_q;
        if (doPush && !doPop) begin
            fill_d = fill_q + FillW'(1);
        end else if (doPop && !doPush) begin
            fill_d = fill_q - FillW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fill_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wrEntry_i;
        end
    end

endmodule

// File: rtl/xadac_vmac.sv
// Vector MAC / dot / add responder on the XADAC execute channel: products registered, then sums into an in-order buffer.
// Build option: define XADAC_VMAC_SATURATE_EN to saturate VMAC/VADD lanes instead of wrapping.
module xadac_vmac
    import xadac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    xadac_ex_if.Slave slv
);
    localparam int CntW = $clog2(DEPTH + 1);

    logic [CntW-1:0]              count_q, count_d;
    logic                         accept;
    logic                         respValid;
    logic                         respFire;
    logic                         fifoEmpty;
    logic                         fifoFull;
    logic                         unusedBits;
    VmacOpT                       reqOp;

    logic                         s1Valid_q;
    IdT                           s1Id_q;
    VmacOpT                       s1Op_q;
    XlenT                         s1Rs1_q;
    VectorT                       s1Vs3_q;
    logic [NLanes-1:0][ProdW-1:0] s1Prod_q, s1Prod_d;

    RespEntryT                    s2Entry;
    RespEntryT                    headEntry;
    XlenT                         dotAcc;

    // The credit count covers both pipeline and buffer, so the buffer can never overflow and stage 1 never stalls.
    assign reqOp         = VmacOpT'(slv.req_imm[1:0]);
    assign slv.req_ready = (count_q < CntW'(DEPTH));
    assign accept        = slv.req_valid && slv.req_ready;
    assign respValid     = !fifoEmpty;
    assign respFire      = respValid && slv.resp_ready;
    assign unusedBits    = ^{slv.req_rs2, slv.req_imm[ImmW-1:2], fifoFull};

    always_comb begin
        count_d = count_q;
        if (accept && !respFire) begin
            count_d = count_q + CntW'(1);
        end else if (respFire && !accept) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            s1Valid_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            s1Valid_q <= accept;
        end
    end

    // VADD reuses the product register to carry its widened lane sum.
    always_comb begin
        s1Prod_d = '0;
        for (int i = 0; i < NLanes; i++) begin
            if (reqOp == VADD) begin
                s1Prod_d[i] = sextLane(slv.req_vs1[i*LaneW +: LaneW])
                            + sextLane(slv.req_vs2[i*LaneW +: LaneW]);
            end else begin
                s1Prod_d[i] = sextLane(slv.req_vs1[i*LaneW +: LaneW])
                            * sextLane(slv.req_vs2[i*LaneW +: LaneW]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1Id_q   <= slv.req_id;
            s1Op_q   <= reqOp;
            s1Rs1_q  <= slv.req_rs1;
            s1Vs3_q  <= slv.req_vs3;
            s1Prod_q <= s1Prod_d;
        end
    end

    always_comb begin
        s2Entry    = '0;
        s2Entry.id = s1Id_q;
        dotAcc     = '0;
        case (s1Op_q)
            VMAC: begin
                for (int i = 0; i < NLanes; i++) begin
`ifdef XADAC_VMAC_SATURATE_EN
                    s2Entry.vd[i*LaneW +: LaneW] = satLane(widenProd(s1Prod_q[i])
                                                 + widenLane(s1Vs3_q[i*LaneW +: LaneW]));
`else
                    s2Entry.vd[i*LaneW +: LaneW] = s1Prod_q[i][LaneW-1:0]
                                                 + s1Vs3_q[i*LaneW +: LaneW];
`endif
                end
            end
            VDOT: begin
                dotAcc = s1Rs1_q;
                for (int i = 0; i < NLanes; i++) begin
                    dotAcc = dotAcc + {{(XLEN - ProdW){s1Prod_q[i][ProdW-1]}}, s1Prod_q[i]};
                end
                s2Entry.rd = dotAcc;
                s2Entry.vd = s1Vs3_q;
            end
            VADD: begin
                for (int i = 0; i < NLanes; i++) begin
`ifdef XADAC_VMAC_SATURATE_EN
                    s2Entry.vd[i*LaneW +: LaneW] = satLane(widenProd(s1Prod_q[i]));
`else
                    s2Entry.vd[i*LaneW +: LaneW] = s1Prod_q[i][LaneW-1:0];
`endif
                end
            end
            default: begin
            end
        endcase
    end

    xadac_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_respFifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (s1Valid_q),
        .wrEntry_i (s2Entry),
        .pop_i     (respFire),
        .rdEntry_o (headEntry),
        .empty_o   (fifoEmpty),
        .full_o    (fifoFull)
    );

    // Response fields read as zero whenever nothing is presented, including straight out of reset.
    assign slv.resp_valid = respValid;
    assign slv.resp_id    = respValid ? headEntry.id : '0;
    assign slv.resp_rd    = respValid ? headEntry.rd : '0;
    assign slv.resp_vd    = respValid ? headEntry.vd : '0;

endmodule

// File: tb/tb_xadac_vmac.sv
// Self-checking bench for xadac_vmac: directed steps plus randomized traffic against a lane-arithmetic reference model.
// Honours XADAC_VMAC_SATURATE_EN in its model so it matches either build.
module tb_xadac_vmac;
    import xadac_pkg::*;

    typedef struct {
        IdT     id;
        XlenT   rd;
        VectorT vd;
    } ExpT;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;
    bit   checkLatency = 1'b0;
    bit   lastAccepted = 1'b0;
    bit   holdPending = 1'b0;
    ExpT  held;
    ExpT  expQ[$];
    int   accQ[$];
    logic [7:0] ovfLane;

    always #5 clk = ~clk;

    xadac_ex_if exIf ();

    xadac_vmac #(
        .DEPTH (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .slv    (exIf)
    );

    function automatic logic [7:0] laneFit(input int r);
        int v;
        v = r;
`ifdef XADAC_VMAC_SATURATE_EN
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
`endif
        return 8'(v);
    endfunction

    // Reference: each lane treated as a signed integer, results computed with plain int arithmetic.
    function automatic ExpT model(input IdT id, input XlenT rs1, input VectorT v1,
                                  input VectorT v2, input VectorT v3, input ImmT imm);
        ExpT        e;
        logic [7:0] la, lb, lc;
        int         a, b, c;
        e.id = id;
        e.rd = '0;
        e.vd = '0;
        for (int i = 0; i < NLanes; i++) begin
            la = v1[i*8 +: 8];
            lb = v2[i*8 +: 8];
            lc = v3[i*8 +: 8];
            a  = int'($signed(la));
            b  = int'($signed(lb));
            c  = int'($signed(lc));
            case (imm[1:0])
                2'd0: e.vd[i*8 +: 8] = laneFit(c + a * b);
                2'd1: e.rd = e.rd + XlenT'(a * b);
                2'd2: e.vd[i*8 +: 8] = laneFit(a + b);
                default: ;
            endcase
        end
        if (imm[1:0] == 2'd1) begin
            e.rd = e.rd + rs1;
            e.vd = v3;
        end
        return e;
    endfunction

    function automatic VectorT splat(input logic [7:0] b);
        return {NLanes{b}};
    endfunction

    function automatic VectorT randVec();
        VectorT v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input IdT id, input XlenT rs1, input VectorT v1,
                                 input VectorT v2, input VectorT v3, input logic [1:0] op);
        exIf.req_id    = id;
        exIf.req_rs1   = rs1;
        exIf.req_rs2   = $urandom;
        exIf.req_vs1   = v1;
        exIf.req_vs2   = v2;
        exIf.req_vs3   = v3;
        exIf.req_imm   = {ImmW'($urandom) >> 2, op};
        exIf.req_valid = 1'b1;
    endtask

    task automatic applyRandom();
        applyStimulus(IdT'($urandom), $urandom, randVec(), randVec(), randVec(), 2'($urandom_range(0, 3)));
    endtask

    task automatic idle();
        exIf.req_valid = 1'b0;
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        ExpT e;
        int  acc;
        @(negedge clk);
        lastAccepted = 1'b0;
        if (holdPending) begin
            checkOutput("hold_valid", exIf.resp_valid, 1'b1);
            checkOutput("hold_id", exIf.resp_id, held.id);
            checkOutput("hold_rd", exIf.resp_rd, held.rd);
            checkOutput("hold_vd", exIf.resp_vd, held.vd);
        end
        holdPending = exIf.resp_valid && !exIf.resp_ready;
        if (holdPending) begin
            held.id = exIf.resp_id;
            held.rd = exIf.resp_rd;
            held.vd = exIf.resp_vd;
        end
        if (exIf.resp_valid && exIf.resp_ready) begin
            checkOutput("resp_expected", expQ.size() > 0, 1'b1);
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                acc = accQ.pop_front();
                checkOutput("resp_id", exIf.resp_id, e.id);
                checkOutput("resp_rd", exIf.resp_rd, e.rd);
                checkOutput("resp_vd", exIf.resp_vd, e.vd);
                if (checkLatency) checkOutput("latency", cycleNo - acc, 2);
            end
        end
        if (exIf.req_valid && exIf.req_ready) begin
            expQ.push_back(model(exIf.req_id, exIf.req_rs1, exIf.req_vs1, exIf.req_vs2,
                                 exIf.req_vs3, exIf.req_imm));
            accQ.push_back(cycleNo);
            lastAccepted = 1'b1;
        end
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && expQ.size() > 0; i++) cycle();
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    initial begin
        VectorT vs3;
        rstN            = 1'b0;
        exIf.req_valid  = 1'b0;
        exIf.req_id     = '0;
        exIf.req_rs1    = '0;
        exIf.req_rs2    = '0;
        exIf.req_vs1    = '0;
        exIf.req_vs2    = '0;
        exIf.req_vs3    = '0;
        exIf.req_imm    = '0;
        exIf.resp_ready = 1'b0;

        #2;
        checkOutput("rst_resp_valid", exIf.resp_valid, 1'b0);
        checkOutput("rst_req_ready", exIf.req_ready, 1'b1);
        checkOutput("rst_resp_id", exIf.resp_id, 0);
        checkOutput("rst_resp_rd", exIf.resp_rd, 0);
        checkOutput("rst_resp_vd", exIf.resp_vd, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput("ready_after_reset", exIf.req_ready, 1'b1);

        // Single VMAC: 1 + 3*4 = 13 in every lane.
        exIf.resp_ready = 1'b1;
        checkLatency    = 1'b1;
        applyStimulus(5'd5, '0, splat(8'd3), splat(8'd4), splat(8'd1), 2'd0);
        cycle();
        idle();
        checkOutput("vmac_not_early", exIf.resp_valid, 1'b0);
        cycle();
        checkOutput("vmac_valid", exIf.resp_valid, 1'b1);
        checkOutput("vmac_id", exIf.resp_id, 5);
        checkOutput("vmac_vd", exIf.resp_vd, splat(8'h0D));
        checkOutput("vmac_rd", exIf.resp_rd, 0);
        cycle();

        // VDOT: 10 + 16 * (2 * -1) = -22.
        vs3 = randVec();
        applyStimulus(5'd9, 32'd10, splat(8'd2), splat(8'hFF), vs3, 2'd1);
        cycle();
        idle();
        cycle();
        checkOutput("vdot_rd", exIf.resp_rd, 32'hFFFF_FFEA);
        checkOutput("vdot_vd", exIf.resp_vd, vs3);
        cycle();

        // Lane overflow: 100 * 2 = 200.
`ifdef XADAC_VMAC_SATURATE_EN
        ovfLane = 8'h7F;
`else
        ovfLane = 8'hC8;
`endif
        applyStimulus(5'd11, '0, splat(8'd100), splat(8'd2), '0, 2'd0);
        cycle();
        idle();
        cycle();
        checkOutput("ovf_vd", exIf.resp_vd, splat(ovfLane));
        cycle();
        drain();

        // Backpressure: four credits, then stall until the first response leaves.
        exIf.resp_ready = 1'b0;
        checkLatency    = 1'b0;
        for (int id = 1; id <= 4; id++) begin
            applyStimulus(IdT'(id), $urandom, randVec(), randVec(), randVec(), 2'($urandom_range(0, 3)));
            cycle();
            checkOutput("bp_accept", lastAccepted, 1'b1);
        end
        checkOutput("bp_ready_drop", exIf.req_ready, 1'b0);
        applyStimulus(5'd5, $urandom, randVec(), randVec(), randVec(), 2'd2);
        cycle();
        checkOutput("bp_stall", lastAccepted, 1'b0);
        cycle();
        checkOutput("bp_stall", lastAccepted, 1'b0);
        exIf.resp_ready = 1'b1;
        cycle();
        checkOutput("bp_id5_wait", lastAccepted, 1'b0);
        checkOutput("bp_ready_back", exIf.req_ready, 1'b1);
        cycle();
        checkOutput("bp_id5_accept", lastAccepted, 1'b1);
        idle();
        drain();

        // Throughput: eight back-to-back requests, each answered exactly two cycles later.
        checkLatency = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyRandom();
            cycle();
            checkOutput("tp_accept", lastAccepted, 1'b1);
        end
        idle();
        drain();

        // Randomized traffic with random backpressure.
        checkLatency = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!exIf.req_valid || lastAccepted) begin
                if ($urandom_range(0, 3) != 0) applyRandom();
                else idle();
            end
            exIf.resp_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        exIf.resp_ready = 1'b1;
        drain();

        // Reset in the middle of work: nothing accepted before it may come back.
        exIf.resp_ready = 1'b0;
        applyStimulus(5'd20, $urandom, randVec(), randVec(), randVec(), 2'd0);
        cycle();
        applyStimulus(5'd21, $urandom, randVec(), randVec(), randVec(), 2'd1);
        cycle();
        idle();
        cycle();
        checkOutput("pre_reset_valid", exIf.resp_valid, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_resp_valid", exIf.resp_valid, 1'b0);
        checkOutput("midrst_req_ready", exIf.req_ready, 1'b1);
        expQ.delete();
        accQ.delete();
        holdPending = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        exIf.resp_ready = 1'b1;
        checkOutput("post_rst_ready", exIf.req_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            checkOutput("no_stale", exIf.resp_valid, 1'b0);
        end
        checkLatency = 1'b1;
        applyRandom();
        cycle();
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
